rv_data_out_queue_bfm: RTL
==========================

# rv_data_out_queue_bfm

Parametrised ready/valid output driver that buffers words pushed by the BFM controller side and replays them on a ready/valid output.
- Programmable idle gap between beats, plus a hold control.
- Synthesizable RTL that sits between the Python-side command interface and the DUT's ready/valid input port.
- Successor to the single-beat output driver: adds depth, throttling and transfer accounting.

## Interface
- DATA_WIDTH, 8, width of data and push_data
- DEPTH, 4, queue entries; power of two, ≥2
- GAP_WIDTH, 8, width of gap_cfg

- clock  input  1  sole clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- push_data  input  DATA_WIDTH  word from controller
- push_valid  input  1  push request
- push_ready  output  1  queue has space
- gap_cfg  input  GAP_WIDTH  idle cycles inserted after each accepted beat
- hold  input  1  when high, no new beat is presented
- data  output  DATA_WIDTH  output word
- data_valid  output  1  output word valid
- data_ready  input  1  sink accepts
- level  output  $clog2(DEPTH)+1  current queue occupancy
- sent_count  output  16  number of accepted output beats

## Operation
- Queue: circular FIFO of DEPTH entries.
  - Write and read pointers wrap at DEPTH.
  - Occupancy counts 0..DEPTH.
- Push: a push occurs at an edge where push_valid && push_ready. push_ready = (level < DEPTH), registered-state only; it has no dependence on data_ready or pop.
- Output head is the oldest queued entry.
  - data = head entry while data_valid=1.
  - data = 0 while data_valid=0.
- Pop/handshake: occurs at an edge where data_valid && data_ready. It removes the head and increments sent_count; sent_count wraps 0xFFFF→0x0000.
- Simultaneous push and pop at the same edge: level unchanged, both take effect. Pushing into a full queue is impossible (push_ready=0) even if a pop occurs that edge.
- State machine: IDLE, VALID, GAP; data_valid = (state==VALID).
  - IDLE→VALID when level≠0 && !hold. Evaluated on registered level, so the entry must already be in the queue before the edge.
  - VALID stays VALID until handshake. hold does not deassert an asserted data_valid, and data is stable while waiting.
  - VALID on handshake:
    - gap_cfg≠0: →GAP, gap counter loaded with gap_cfg (sampled at that edge).
    - gap_cfg=0 and level after pop ≠0 and !hold: stay VALID; next head is presented the following cycle.
    - otherwise: →IDLE.
  - GAP: counter decrements each edge. When the counter is 1 at an edge, the next state is VALID if (level≠0 && !hold), else IDLE.
- gap_cfg changes outside the handshake edge have no effect on an in-progress gap.

## Timing
- Reset values:
  - state=IDLE, data_valid=0, data=0.
  - level=0, push_ready=1, sent_count=0.
  - Pointers=0, gap counter=0.
- Reset mid-transfer: queue discarded and data_valid drops immediately (asynchronous); nothing is replayed after release.
- Latency: a push at edge k into an empty idle queue gives data_valid=1 after edge k+1. One bubble cycle; there is no combinational push→data path.
- Back-to-back throughput: 1 beat/cycle with gap_cfg=0, data_ready=1 and a non-empty queue.
- With gap_cfg=G>0: exactly G cycles of data_valid=0 between consecutive beats, if data remains queued and hold=0.
- level and push_ready update on the edge following the push/pop.
- hold asserted during GAP or IDLE: data_valid stays 0 until the first edge where hold=0 and level≠0; data_valid rises one cycle later.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with gap_cfg=0 and data_ready=1 → data_valid rises 2 cycles after first push; data sequence 0x11, 0x22, 0x33 on consecutive cycles; sent_count=3.
- DEPTH=4: push 5 words with data_ready=0 → push_ready falls after the 4th push and level=4. Raise data_ready → the 5th push is accepted after the first pop; order is preserved.
- gap_cfg=3, 4 words queued, data_ready=1 → exactly 3 low cycles of data_valid between each beat; sent_count=4.
- data_ready=0 for 5 cycles while data_valid=1, with hold toggled → data_valid and data stay stable; a single beat is counted on release.
- Assert reset while 3 words are queued and data_valid=1 → data_valid=0 and level=0 immediately. After release, no beat appears until a new push.
- Drive 65536 beats → sent_count wraps to 0x0000.

Source files
------------

// File: rtl/rv_data_out_queue_bfm.sv
// Queued ready/valid output driver for the BFM controller.
// Replays pushed words with a programmable idle gap and a hold control.
module rv_data_out_queue_bfm #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int GAP_WIDTH  = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [DATA_WIDTH-1:0]  push_data,
   input  logic                   push_valid,
   output logic                   push_ready,
   input  logic [GAP_WIDTH-1:0]   gap_cfg,
   input  logic                   hold,
   output logic [DATA_WIDTH-1:0]  data,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]            sent_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_VALID,
      S_GAP
   } state_e;

   state_e                state_q;
   logic [GAP_WIDTH-1:0]  gap_q;
   logic [AW-1:0]         wptr_q;
   logic [AW-1:0]         rptr_q;
   logic [LW-1:0]         level_q;
   logic [LW-1:0]         level_d;
   logic [15:0]           sent_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic push;
   logic pop;
   logic has_data;

   assign push_ready = (level_q != LW'(DEPTH));
   assign data_valid = (state_q == S_VALID);
   assign data       = data_valid ? mem_q[rptr_q] : '0;
   assign level      = level_q;
   assign sent_count = sent_q;

   assign push     = push_valid && push_ready;
   assign pop      = data_valid && data_ready;
   assign has_data = (level_q != '0);
   assign level_d  = level_q + LW'(push) - LW'(pop);

   // Storage carries no reset; pointers and level define what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wptr_q] <= push_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         sent_q  <= '0;
      end else begin
         level_q <= level_d;
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
            sent_q <= sent_q + 16'd1;
         end
         unique case (state_q)
            S_IDLE: begin
               if (has_data && !hold) begin
                  state_q <= S_VALID;
               end
            end
            S_VALID: begin
               if (pop) begin
                  if (gap_cfg != '0) begin
                     state_q <= S_GAP;
                     gap_q   <= gap_cfg;
                  end else if (level_q != LW'(1) && !hold) begin
                     state_q <= S_VALID;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               gap_q <= gap_q - GAP_WIDTH'(1);
               if (gap_q == GAP_WIDTH'(1)) begin
                  state_q <= (has_data && !hold) ? S_VALID : S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
